// File: rtl/loss_batch_accum.sv
// Batched squared-error loss: 2-stage (diff, square) pipeline feeding a batch accumulator.
// Optional LOSS_BATCH_MAX_EN adds max_o, the largest per-sample square in the batch.
module loss_batch_accum #(
    parameter int PRED_W     = 23,
    parameter int TGT_W      = 4,
    parameter int BATCH_LOG2 = 3,
    localparam int SQ_W  = 2*PRED_W+2,
    localparam int SUM_W = SQ_W+BATCH_LOG2,
    localparam int CNT_W = BATCH_LOG2+1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [PRED_W-1:0] predicted_i,
    input  logic [TGT_W-1:0]  target_i,
    input  logic              flush_i,
    output logic              sq_valid_o,
    output logic [SQ_W-1:0]   sq_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [SUM_W-1:0]  sum_o,
    output logic [CNT_W-1:0]  cnt_o,
    output logic [SQ_W-1:0]   mean_o
`ifdef LOSS_BATCH_MAX_EN
    ,
    output logic [SQ_W-1:0]   max_o
`endif
);

    localparam int STAGES = 2;
    localparam int unsigned N_INT = 1 << BATCH_LOG2;
    localparam logic [CNT_W-1:0] N = CNT_W'(N_INT);

    typedef enum logic [1:0] {COLLECT, DRAIN, OUTPUT} state_t;

    state_t                  state_q;
    logic [STAGES:1]         vld_pipe;
    logic signed [PRED_W:0]  diff_q;
    logic signed [SQ_W-1:0]  diff_ext;
    logic [SQ_W-1:0]         sq_q;
    logic [SUM_W-1:0]        acc_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [CNT_W-1:0]        cnt_inc;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    accept;
    logic                    handshake;
    logic                    batch_full;
    logic                    flush_hit;

    assign accept     = in_valid_i && in_ready_q;
    assign handshake  = out_valid_q && out_ready_i;
    assign cnt_inc    = cnt_q + CNT_W'(accept);
    assign batch_full = accept && (cnt_inc == N);
    // A flush counts a sample accepted in the same cycle; an empty batch ignores it.
    assign flush_hit  = flush_i && (cnt_inc != '0);
    assign diff_ext   = {{(SQ_W-PRED_W-1){diff_q[PRED_W]}}, diff_q};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_pipe <= '0;
            diff_q   <= '0;
            sq_q     <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            if (accept)
                diff_q <= $signed({predicted_i[PRED_W-1], predicted_i})
                        - $signed({{(PRED_W+1-TGT_W){1'b0}}, target_i});
            // Full-width signed product: the square of a PRED_W+1 value always fits SQ_W.
            if (vld_pipe[1])
                sq_q <= diff_ext * diff_ext;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= COLLECT;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
        end else begin
            if (vld_pipe[STAGES])
                acc_q <= acc_q + SUM_W'(sq_q);
            case (state_q)
                COLLECT: begin
                    in_ready_q <= 1'b1;
                    cnt_q      <= cnt_inc;
                    if (batch_full || flush_hit) begin
                        state_q    <= DRAIN;
                        in_ready_q <= 1'b0;
                    end
                end
                // Once stage 1 is empty, the last square lands in acc on this same edge.
                DRAIN: begin
                    if (!vld_pipe[1]) begin
                        state_q     <= OUTPUT;
                        out_valid_q <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (handshake) begin
                        state_q     <= COLLECT;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        cnt_q       <= '0;
                        acc_q       <= '0;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

`ifdef LOSS_BATCH_MAX_EN
    logic [SQ_W-1:0] max_q;

    always_ff @(posedge clk_i) begin
        if (rst_i)
            max_q <= '0;
        else if (handshake)
            max_q <= '0;
        else if (vld_pipe[STAGES] && (sq_q > max_q))
            max_q <= sq_q;
    end

    assign max_o = max_q;
`else
    // No max tracking in this build.
`endif

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign sq_valid_o  = vld_pipe[STAGES];
    assign sq_o        = sq_q;
    assign sum_o       = acc_q;
    assign cnt_o       = cnt_q;
    assign mean_o      = (cnt_q == N) ? SQ_W'(acc_q >> BATCH_LOG2) : '0;

endmodule
